// File: rtl/decode_instr_window_pkg.sv
// decode_instr_window_pkg: prefix byte constants, segment codes, flag indices and FSM encoding
package decode_instr_window_pkg;
  localparam int WINDOW_BYTES_DEF = 9;
  localparam int MAX_INSTR_LEN_DEF = 15;
  localparam int MAX_PREFIXES_DEF = 4;
  localparam logic [7:0] PFX_OPSIZE = 8'h66;
  localparam logic [7:0] PFX_ADDR = 8'h67;
  localparam logic [7:0] PFX_LOCK = 8'hF0;
  localparam logic [7:0] PFX_REP = 8'hF3;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_ES = 8'h26;
  localparam logic [7:0] PFX_CS = 8'h2E;
  localparam logic [7:0] PFX_SS = 8'h36;
  localparam logic [7:0] PFX_DS = 8'h3E;
  localparam logic [7:0] PFX_FS = 8'h64;
  localparam logic [7:0] PFX_GS = 8'h65;
  localparam logic [7:0] ESCAPE_BYTE = 8'h0F;
  localparam logic [2:0] PREFIX_SEG_NONE = 3'd0;
  localparam logic [2:0] PREFIX_SEG_ES = 3'd1;
  localparam logic [2:0] PREFIX_SEG_CS = 3'd2;
  localparam logic [2:0] PREFIX_SEG_SS = 3'd3;
  localparam logic [2:0] PREFIX_SEG_DS = 3'd4;
  localparam logic [2:0] PREFIX_SEG_FS = 3'd5;
  localparam logic [2:0] PREFIX_SEG_GS = 3'd6;
  localparam int FLAG_OPSIZE = 0;
  localparam int FLAG_ADDR = 1;
  localparam int FLAG_LOCK = 2;
  localparam int FLAG_REP = 3;
  localparam int FLAG_REPNE = 4;
  localparam int NUM_FLAGS = 5;
  typedef enum logic [1:0] {ST_PREFIX, ST_BODY, ST_EMIT} state_t;
endpackage

// File: rtl/decode_instr_window_prefix_classify.sv
// decode_prefix_classify: combinational byte classifier into prefix flag, segment code and escape
module decode_prefix_classify
  import decode_instr_window_pkg::*;
(
  input  logic [7:0]           byte_in,
  output logic                 is_prefix,
  output logic                 is_escape,
  output logic [NUM_FLAGS-1:0] flag,
  output logic [2:0]           seg
);
  always_comb begin
    flag = '0;
    seg = PREFIX_SEG_NONE;
    case (byte_in)
      PFX_OPSIZE: flag[FLAG_OPSIZE] = 1'b1;
      PFX_ADDR:   flag[FLAG_ADDR] = 1'b1;
      PFX_LOCK:   flag[FLAG_LOCK] = 1'b1;
      PFX_REP:    flag[FLAG_REP] = 1'b1;
      PFX_REPNE:  flag[FLAG_REPNE] = 1'b1;
      PFX_ES:     seg = PREFIX_SEG_ES;
      PFX_CS:     seg = PREFIX_SEG_CS;
      PFX_SS:     seg = PREFIX_SEG_SS;
      PFX_DS:     seg = PREFIX_SEG_DS;
      PFX_FS:     seg = PREFIX_SEG_FS;
      PFX_GS:     seg = PREFIX_SEG_GS;
      default:    ;
    endcase
  end
  assign is_prefix = |flag || seg != PREFIX_SEG_NONE;
  assign is_escape = byte_in == ESCAPE_BYTE;
endmodule

// File: rtl/decode_instr_window.sv
// decode_instr_window: strips prefixes/escape from a byte stream and holds an opcode-aligned window
module decode_instr_window
  import decode_instr_window_pkg::*;
#(
  parameter int WINDOW_BYTES = WINDOW_BYTES_DEF,
  parameter int MAX_INSTR_LEN = MAX_INSTR_LEN_DEF,
  parameter int MAX_PREFIXES = MAX_PREFIXES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  input  logic                      byte_last,
  output logic                      byte_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*WINDOW_BYTES-1:0] unescaped_instr,
  output logic                      is_escaped,
  output logic                      prefix_opsize_16bit,
  output logic                      prefix_address_16bit,
  output logic                      prefix_lock,
  output logic                      prefix_rep,
  output logic                      prefix_repne,
  output logic [2:0]                prefix_seg,
  output logic [3:0]                instr_len,
  output logic                      frame_err
);
  localparam int WW = 8 * WINDOW_BYTES;
  localparam int IW = $clog2(WINDOW_BYTES + 1);
  localparam int PW = $clog2(MAX_PREFIXES + 2);
  localparam int LW = $clog2(MAX_INSTR_LEN + 2);
  state_t state, state_next;
  logic [WW-1:0] window;
  logic [NUM_FLAGS-1:0] flags, c_flag;
  logic [2:0] seg, c_seg;
  logic escaped, err, c_prefix, c_escape;
  logic [IW-1:0] body_idx, wr_idx;
  logic [PW-1:0] prefix_cnt;
  logic [LW-1:0] len, len_next;
  logic acc, in_prefix, body_full, pc_full, wr_en, err_set, clear;
  decode_prefix_classify u_classify (
    .byte_in   (byte_data),
    .is_prefix (c_prefix),
    .is_escape (c_escape),
    .flag      (c_flag),
    .seg       (c_seg)
  );
  assign byte_ready = state != ST_EMIT;
  assign out_valid = state == ST_EMIT;
  always_comb begin
    acc = byte_valid && byte_ready;
    in_prefix = state == ST_PREFIX;
    body_full = body_idx == IW'(WINDOW_BYTES);
    pc_full = prefix_cnt == PW'(MAX_PREFIXES);
    len_next = len == LW'(MAX_INSTR_LEN + 1) ? len : len + LW'(1);
    wr_en = acc && (in_prefix ? !c_prefix && !c_escape : !body_full);
    wr_idx = in_prefix ? '0 : body_idx;
    err_set = acc && (len_next > LW'(MAX_INSTR_LEN) || (in_prefix ?
      (c_prefix && pc_full) || (byte_last && (c_prefix || c_escape)) : body_full));
    clear = reset || (state == ST_EMIT && out_ready);
    state_next = state;
    if (state == ST_EMIT) state_next = out_ready ? ST_PREFIX : ST_EMIT;
    else if (acc) state_next = byte_last ? ST_EMIT : (in_prefix && !c_prefix) ? ST_BODY : state;
  end
  always_ff @(posedge clk) state <= reset ? ST_PREFIX : state_next;
  always_ff @(posedge clk) begin
    if (clear) begin
      window <= '0;
      flags <= '0;
      seg <= PREFIX_SEG_NONE;
      escaped <= 1'b0;
      err <= 1'b0;
      body_idx <= '0;
      prefix_cnt <= '0;
      len <= '0;
    end else if (acc) begin
      len <= len_next;
      err <= err | err_set;
      if (wr_en) window <= window | (WW'(byte_data) << {wr_idx, 3'b000});
      if (in_prefix) begin
        flags <= flags | c_flag;
        seg <= c_seg != PREFIX_SEG_NONE ? c_seg : seg;
        escaped <= escaped | c_escape;
        prefix_cnt <= (c_prefix && !pc_full) ? prefix_cnt + PW'(1) : prefix_cnt;
        body_idx <= (c_prefix || c_escape) ? body_idx : IW'(1);
      end else if (!body_full) body_idx <= body_idx + IW'(1);
    end
  end
  assign unescaped_instr = window;
  assign is_escaped = escaped;
  assign prefix_opsize_16bit = flags[FLAG_OPSIZE];
  assign prefix_address_16bit = flags[FLAG_ADDR];
  assign prefix_lock = flags[FLAG_LOCK];
  assign prefix_rep = flags[FLAG_REP];
  assign prefix_repne = flags[FLAG_REPNE];
  assign prefix_seg = seg;
  assign instr_len = len > LW'(15) ? 4'd15 : 4'(len);
  assign frame_err = err;
endmodule

// File: tb/tb_decode_instr_window.sv
// tb_decode_instr_window: directed self-checking bench for decode_instr_window
module tb_decode_instr_window;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_last = 1'b0;
  logic byte_ready, out_valid;
  logic out_ready = 1'b0;
  logic [71:0] unescaped_instr;
  logic is_escaped, prefix_opsize_16bit, prefix_address_16bit, prefix_lock, prefix_rep, prefix_repne;
  logic [2:0] prefix_seg;
  logic [3:0] instr_len;
  logic frame_err;
  int n_cmp = 0;
  int n_bad = 0;
  wire [8:0] flags_w = {is_escaped, prefix_opsize_16bit, prefix_address_16bit, prefix_lock,
                        prefix_rep, prefix_repne, prefix_seg};
  always #5 clk = ~clk;
  decode_instr_window dut (
    .clk                  (clk),
    .reset                (reset),
    .byte_valid           (byte_valid),
    .byte_data            (byte_data),
    .byte_last            (byte_last),
    .byte_ready           (byte_ready),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .unescaped_instr      (unescaped_instr),
    .is_escaped           (is_escaped),
    .prefix_opsize_16bit  (prefix_opsize_16bit),
    .prefix_address_16bit (prefix_address_16bit),
    .prefix_lock          (prefix_lock),
    .prefix_rep           (prefix_rep),
    .prefix_repne         (prefix_repne),
    .prefix_seg           (prefix_seg),
    .instr_len            (instr_len),
    .frame_err            (frame_err)
  );
  task automatic send(input logic [7:0] b, input logic l);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    byte_last = l;
    @(posedge clk);
  endtask
  task automatic end_frame();
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last = 1'b0;
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (byte_ready !== 1'b1) begin n_bad++; $display("FAIL reset_byte_ready: got %b want 1", byte_ready); end
    n_cmp++; if (unescaped_instr !== 72'h0) begin n_bad++; $display("FAIL reset_window: got %h want 0", unescaped_instr); end
    n_cmp++; if (flags_w !== 9'h0) begin n_bad++; $display("FAIL reset_flags: got %h want 0", flags_w); end
    n_cmp++; if ({instr_len, frame_err} !== 5'h0) begin n_bad++; $display("FAIL reset_len_err: got %h want 0", {instr_len, frame_err}); end
    reset = 1'b0;
  endtask
  task automatic test_plain();
    send(8'h01, 1'b0);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data = 8'hD8;
    byte_last = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL plain_early_valid: got %b want 0", out_valid); end
    @(posedge clk);
    end_frame();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL plain_latency: got %b want 1", out_valid); end
    n_cmp++; if (unescaped_instr !== 72'hD801) begin n_bad++; $display("FAIL plain_window: got %h want %h", unescaped_instr, 72'hD801); end
    n_cmp++; if (flags_w !== 9'h0) begin n_bad++; $display("FAIL plain_flags: got %h want 0", flags_w); end
    n_cmp++; if (instr_len !== 4'd2) begin n_bad++; $display("FAIL plain_len: got %0d want 2", instr_len); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL plain_err: got %b want 0", frame_err); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL plain_consumed: got %b want 0", out_valid); end
  endtask
  task automatic test_prefixes();
    send(8'h66, 1'b0);
    send(8'h67, 1'b0);
    send(8'h8B, 1'b0);
    send(8'h04, 1'b0);
    send(8'h24, 1'b1);
    end_frame();
    n_cmp++; if (flags_w !== 9'b0_11000_000) begin n_bad++; $display("FAIL pfx_flags: got %b want 011000000", flags_w); end
    n_cmp++; if (unescaped_instr !== 72'h24048B) begin n_bad++; $display("FAIL pfx_window: got %h want %h", unescaped_instr, 72'h24048B); end
    n_cmp++; if ({instr_len, frame_err} !== {4'd5, 1'b0}) begin n_bad++; $display("FAIL pfx_len_err: got %0d/%b want 5/0", instr_len, frame_err); end
    consume();
  endtask
  task automatic test_escape();
    send(8'h0F, 1'b0);
    send(8'hAF, 1'b0);
    send(8'hC3, 1'b1);
    end_frame();
    n_cmp++; if (flags_w !== 9'b1_00000_000) begin n_bad++; $display("FAIL esc_flags: got %b want 100000000", flags_w); end
    n_cmp++; if (unescaped_instr !== 72'hC3AF) begin n_bad++; $display("FAIL esc_window: got %h want %h", unescaped_instr, 72'hC3AF); end
    n_cmp++; if ({instr_len, frame_err} !== {4'd3, 1'b0}) begin n_bad++; $display("FAIL esc_len_err: got %0d/%b want 3/0", instr_len, frame_err); end
    consume();
  endtask
  task automatic test_body_overflow();
    send(8'h64, 1'b0);
    for (int i = 1; i <= 10; i++) send(8'(i), i == 10);
    end_frame();
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", frame_err); end
    n_cmp++; if (prefix_seg !== 3'd5) begin n_bad++; $display("FAIL ovf_seg: got %0d want 5", prefix_seg); end
    n_cmp++; if (instr_len !== 4'd11) begin n_bad++; $display("FAIL ovf_len: got %0d want 11", instr_len); end
    consume();
    send(8'h64, 1'b0);
    for (int i = 1; i <= 9; i++) send(8'(8'h10 + i), i == 9);
    end_frame();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL full9_err: got %b want 0", frame_err); end
    n_cmp++; if (unescaped_instr !== 72'h191817161514131211) begin n_bad++; $display("FAIL full9_window: got %h want %h", unescaped_instr, 72'h191817161514131211); end
    consume();
    send(8'h65, 1'b0);
    for (int i = 1; i <= 15; i++) send(8'(i), i == 15);
    end_frame();
    n_cmp++; if ({instr_len, frame_err} !== {4'd15, 1'b1}) begin n_bad++; $display("FAIL len_sat: got %0d/%b want 15/1", instr_len, frame_err); end
    n_cmp++; if (prefix_seg !== 3'd6) begin n_bad++; $display("FAIL len_sat_seg: got %0d want 6", prefix_seg); end
    consume();
  endtask
  task automatic test_malformed();
    send(8'hF3, 1'b1);
    end_frame();
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL pfx_only_err: got %b want 1", frame_err); end
    n_cmp++; if (flags_w !== 9'b0_00010_000) begin n_bad++; $display("FAIL pfx_only_flags: got %b want 000010000", flags_w); end
    consume();
    send(8'h0F, 1'b1);
    end_frame();
    n_cmp++; if ({is_escaped, frame_err} !== 2'b11) begin n_bad++; $display("FAIL esc_only: got %b want 11", {is_escaped, frame_err}); end
    consume();
    repeat (5) send(8'h2E, 1'b0);
    send(8'h90, 1'b1);
    end_frame();
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL five_pfx_err: got %b want 1", frame_err); end
    n_cmp++; if ({prefix_seg, instr_len} !== {3'd2, 4'd6}) begin n_bad++; $display("FAIL five_pfx_seg_len: got %0d/%0d want 2/6", prefix_seg, instr_len); end
    consume();
    send(8'hF0, 1'b0);
    send(8'hF2, 1'b0);
    send(8'h26, 1'b0);
    send(8'h36, 1'b0);
    send(8'h90, 1'b1);
    end_frame();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL four_pfx_err: got %b want 0", frame_err); end
    n_cmp++; if (flags_w !== 9'b0_00101_011) begin n_bad++; $display("FAIL four_pfx_flags: got %b want 000101011", flags_w); end
    n_cmp++; if (unescaped_instr !== 72'h90) begin n_bad++; $display("FAIL four_pfx_window: got %h want 90", unescaped_instr); end
    consume();
  endtask
  task automatic test_hold_and_reset();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({out_valid, byte_ready} !== 2'b01) begin n_bad++; $display("FAIL idle_ready: got %b want 01", {out_valid, byte_ready}); end
    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'hD8, 1'b1);
    end_frame();
    byte_valid = 1'b1;
    byte_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({out_valid, byte_ready} !== 2'b10) begin n_bad++; $display("FAIL hold_hs_%0d: got %b want 10", i, {out_valid, byte_ready}); end
      n_cmp++; if ({unescaped_instr, instr_len} !== {72'hD801, 4'd2}) begin n_bad++; $display("FAIL hold_data_%0d: got %h/%0d want D801/2", i, unescaped_instr, instr_len); end
    end
    byte_valid = 1'b0;
    consume();
    send(8'h66, 1'b0);
    send(8'h01, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({out_valid, byte_ready} !== 2'b01) begin n_bad++; $display("FAIL midrst_hs: got %b want 01", {out_valid, byte_ready}); end
    n_cmp++; if (unescaped_instr !== 72'h0) begin n_bad++; $display("FAIL midrst_window: got %h want 0", unescaped_instr); end
    n_cmp++; if ({flags_w, instr_len, frame_err} !== 14'h0) begin n_bad++; $display("FAIL midrst_flags: got %h want 0", {flags_w, instr_len, frame_err}); end
    send(8'h90, 1'b1);
    end_frame();
    n_cmp++; if ({unescaped_instr, instr_len} !== {72'h90, 4'd1}) begin n_bad++; $display("FAIL postrst_frame: got %h/%0d want 90/1", unescaped_instr, instr_len); end
    n_cmp++; if ({flags_w, frame_err} !== 10'h0) begin n_bad++; $display("FAIL postrst_flags: got %h want 0", {flags_w, frame_err}); end
    consume();
  endtask
  initial begin
    test_reset();
    test_plain();
    test_prefixes();
    test_escape();
    test_body_overflow();
    test_malformed();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
